// File: rtl/sync_pfifo_pkg.sv
// Shared helpers for the single-clock prefetch width-converting FIFO:
// width derivation functions and the conversion-direction enum.
package sync_pfifo_pkg;

    typedef enum logic [1:0] {
        WC_EQUAL,
        WC_PACK,
        WC_UNPACK
    } wc_dir_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned mem_w(input int unsigned wr_w, input int unsigned rd_w);
        return (wr_w > rd_w) ? wr_w : rd_w;
    endfunction

    function automatic int unsigned ratio(input int unsigned wr_w, input int unsigned rd_w);
        return (wr_w > rd_w) ? (wr_w / rd_w) : (rd_w / wr_w);
    endfunction

    function automatic int unsigned sub_w(input int unsigned wr_w, input int unsigned rd_w);
        return (wr_w < rd_w) ? wr_w : rd_w;
    endfunction

    // Lane counters keep at least one bit so equal-width builds stay legal.
    function automatic int unsigned idx_w(input int unsigned wr_w, input int unsigned rd_w);
        int unsigned b;
        b = clog2(ratio(wr_w, rd_w));
        return (b == 0) ? 1 : b;
    endfunction

    function automatic wc_dir_e wc_dir(input int unsigned wr_w, input int unsigned rd_w);
        if (wr_w == rd_w) begin
            return WC_EQUAL;
        end
        return (rd_w > wr_w) ? WC_PACK : WC_UNPACK;
    endfunction

endpackage

// File: rtl/sync_pfifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array has no reset; readers qualify rdata themselves.
module sync_pfifo_sdp_ram
    import sync_pfifo_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_prefetch_wconv_fifo.sv
// Single-clock first-word-fall-through FIFO with power-of-2 width conversion.
// Optional occupancy port enabled by `define SYNC_PFIFO_LEVEL_EN.
module sync_prefetch_wconv_fifo
    import sync_pfifo_pkg::*;
#(
    parameter int unsigned WR_DATA_WIDTH = 128,
    parameter int unsigned RD_DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH    = 9,
    parameter int unsigned LSB_FIRST     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    output logic                     wr_vld,
    input  logic [WR_DATA_WIDTH-1:0] wr_data,
    input  logic                     rd_en,
    output logic                     rd_vld,
    output logic [RD_DATA_WIDTH-1:0] rd_data,
`ifdef SYNC_PFIFO_LEVEL_EN
    output logic [ADDR_WIDTH+1:0]    level,
`endif
    output logic                     wr_ovf
);

    localparam int unsigned MEM_W = mem_w(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int unsigned RATIO = ratio(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int unsigned IDX_W = idx_w(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam wc_dir_e     DIR   = wc_dir(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int unsigned WR_R  = (DIR == WC_PACK)   ? RATIO : 1;
    localparam int unsigned RD_R  = (DIR == WC_UNPACK) ? RATIO : 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [MEM_W-1:0] WR_MASK = MEM_W'({WR_DATA_WIDTH{1'b1}});

    logic [ADDR_WIDTH-1:0]    wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0]    rptr_q, rptr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     full_q, full_d;
    logic                     head_ok_q, head_ok_d;
    logic [MEM_W-1:0]         pack_q, pack_d;
    logic [IDX_W-1:0]         pcnt_q, pcnt_d;
    logic [MEM_W-1:0]         out_q, out_d;
    logic                     out_vld_q, out_vld_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [RD_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                     ovf_q, ovf_d;

    logic [MEM_W-1:0] pack_ins;
    logic [MEM_W-1:0] ram_rdata;
    logic             wr_acc, commit, pop, free_entry, load;
    int unsigned      wr_lane, rd_lane;

    // Write side: lane insertion into the pack register, commit on the last lane.
    always_comb begin
        wr_acc   = wr_en && !full_q;
        wr_lane  = (LSB_FIRST != 0) ? 32'(pcnt_q) : (WR_R - 1 - 32'(pcnt_q));
        pack_ins = (pack_q & ~(WR_MASK << (wr_lane * WR_DATA_WIDTH)))
                 | (MEM_W'(wr_data) << (wr_lane * WR_DATA_WIDTH));
        commit   = wr_acc && (pcnt_q == IDX_W'(WR_R - 1));
        pack_d   = pack_q;
        pcnt_d   = pcnt_q;
        wptr_d   = wptr_q;
        if (wr_acc) begin
            pack_d = pack_ins;
            pcnt_d = commit ? '0 : pcnt_q + 1'b1;
        end
        if (commit) begin
            wptr_d = wptr_q + 1'b1;
        end
        ovf_d = ovf_q || (wr_en && full_q);
    end

    // Read side: pop/unpack and prefetch of the RAM head into the output stage.
    always_comb begin
        pop        = rd_en && out_vld_q;
        free_entry = pop && (idx_q == IDX_W'(RD_R - 1));
        load       = head_ok_q && (!out_vld_q || free_entry);
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        idx_d      = idx_q;
        rptr_d     = rptr_q;
        if (pop) begin
            idx_d = free_entry ? '0 : idx_q + 1'b1;
        end
        if (load) begin
            out_d     = ram_rdata;
            out_vld_d = 1'b1;
            rptr_d    = rptr_q + 1'b1;
        end else if (free_entry) begin
            out_vld_d = 1'b0;
        end
        rd_lane   = (LSB_FIRST != 0) ? 32'(idx_d) : (RD_R - 1 - 32'(idx_d));
        rd_data_d = RD_DATA_WIDTH'(out_d >> (rd_lane * RD_DATA_WIDTH));
    end

    // RAM occupancy; a head written on this edge is not yet readable next cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (commit && !load) begin
            cnt_d = cnt_q + 1'b1;
        end else if (load && !commit) begin
            cnt_d = cnt_q - 1'b1;
        end
        full_d    = (cnt_d == CNT_W'(DEPTH));
        head_ok_d = (cnt_d != '0) && !(commit && (cnt_d == CNT_W'(1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            head_ok_q <= 1'b0;
            pack_q    <= '0;
            pcnt_q    <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            idx_q     <= '0;
            rd_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            head_ok_q <= head_ok_d;
            pack_q    <= pack_d;
            pcnt_q    <= pcnt_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            idx_q     <= idx_d;
            rd_data_q <= rd_data_d;
            ovf_q     <= ovf_d;
        end
    end

    sync_pfifo_sdp_ram #(
        .DATA_W (MEM_W),
        .ADDR_W (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (commit),
        .waddr (wptr_q),
        .wdata (pack_ins),
        .raddr (rptr_d),
        .rdata (ram_rdata)
    );

`ifdef SYNC_PFIFO_LEVEL_EN
    logic [ADDR_WIDTH+1:0] level_q, level_d;

    // Committed entries held anywhere: RAM plus output stage.
    always_comb begin
        level_d = level_q;
        if (commit && !free_entry) begin
            level_d = level_q + 1'b1;
        end else if (free_entry && !commit) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
`endif

    // Write-ready is held low for the whole reset window.
    assign wr_vld  = !full_q && !rst;
    assign rd_vld  = out_vld_q;
    assign rd_data = rd_data_q;
    assign wr_ovf  = ovf_q;

endmodule

// File: tb/tb_sync_prefetch_wconv_fifo.sv
// Directed bench for sync_prefetch_wconv_fifo: 128->16, 16->128 and 128->128 instances.
// Level checks are compiled in with `define SYNC_PFIFO_LEVEL_EN.
module tb_sync_prefetch_wconv_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // a: 128->16 AW=9, b: 16->128 AW=4, c: 128->128 AW=4
    logic         a_rst, a_wr_en, a_wr_vld, a_rd_en, a_rd_vld, a_wr_ovf;
    logic [127:0] a_wr_data;
    logic [15:0]  a_rd_data;
    logic         b_rst, b_wr_en, b_wr_vld, b_rd_en, b_rd_vld, b_wr_ovf;
    logic [15:0]  b_wr_data;
    logic [127:0] b_rd_data;
    logic         c_rst, c_wr_en, c_wr_vld, c_rd_en, c_rd_vld, c_wr_ovf;
    logic [127:0] c_wr_data;
    logic [127:0] c_rd_data;
`ifdef SYNC_PFIFO_LEVEL_EN
    logic [10:0]  a_level;
    logic [5:0]   b_level;
    logic [5:0]   c_level;
`endif

    sync_prefetch_wconv_fifo #(.WR_DATA_WIDTH(128), .RD_DATA_WIDTH(16), .ADDR_WIDTH(9), .LSB_FIRST(1)) u_a (
`ifdef SYNC_PFIFO_LEVEL_EN
        .level(a_level),
`endif
        .clk(clk), .rst(a_rst), .wr_en(a_wr_en), .wr_vld(a_wr_vld), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_vld(a_rd_vld), .rd_data(a_rd_data), .wr_ovf(a_wr_ovf)
    );

    sync_prefetch_wconv_fifo #(.WR_DATA_WIDTH(16), .RD_DATA_WIDTH(128), .ADDR_WIDTH(4), .LSB_FIRST(1)) u_b (
`ifdef SYNC_PFIFO_LEVEL_EN
        .level(b_level),
`endif
        .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_vld(b_wr_vld), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_vld(b_rd_vld), .rd_data(b_rd_data), .wr_ovf(b_wr_ovf)
    );

    sync_prefetch_wconv_fifo #(.WR_DATA_WIDTH(128), .RD_DATA_WIDTH(128), .ADDR_WIDTH(4), .LSB_FIRST(1)) u_c (
`ifdef SYNC_PFIFO_LEVEL_EN
        .level(c_level),
`endif
        .clk(clk), .rst(c_rst), .wr_en(c_wr_en), .wr_vld(c_wr_vld), .wr_data(c_wr_data),
        .rd_en(c_rd_en), .rd_vld(c_rd_vld), .rd_data(c_rd_data), .wr_ovf(c_wr_ovf)
    );

    typedef struct packed {
        logic         wr_en;
        logic [127:0] wr_data;
        logic         rd_en;
        logic         exp_wr_vld;
        logic         exp_rd_vld;
        logic [15:0]  exp_rd_data;
    } vec_t;

    localparam int NV = 33;
    vec_t tv [NV];

    task automatic chk1(input string nm, input logic act, input logic exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %b want %b", nm, act, exp_v);
        end
    endtask

    task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [127:0] c_val(input int i);
        return {96'hC3C3C3C3_C3C3C3C3_C3C3C3C3, 32'(i)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nread;
        int gaps;
        int stalls;

        // T1 vector table: 128->16 single word, hold, drain, then two back-to-back words
        for (int i = 0; i < NV; i++) begin
            tv[i] = '0;
            tv[i].exp_wr_vld = 1'b1;
        end
        tv[0].wr_en   = 1'b1;
        tv[0].wr_data = 128'h0F0E0D0C0B0A09080706050403020100;
        tv[3].exp_rd_vld  = 1'b1;
        tv[3].exp_rd_data = 16'h0100;
        for (int j = 0; j < 8; j++) begin
            tv[4 + j].rd_en       = 1'b1;
            tv[4 + j].exp_rd_vld  = 1'b1;
            tv[4 + j].exp_rd_data = {8'(2 * j + 1), 8'(2 * j)};
        end
        tv[13].wr_en   = 1'b1;
        tv[13].wr_data = 128'h2007200620052004200320022001200;
        tv[13].wr_data = 128'h20072006200520042003200220012000;
        tv[14].wr_en   = 1'b1;
        tv[14].wr_data = 128'h30073006300530043003300230013000;
        for (int j = 0; j < 8; j++) begin
            tv[16 + j].rd_en       = 1'b1;
            tv[16 + j].exp_rd_vld  = 1'b1;
            tv[16 + j].exp_rd_data = 16'h2000 + 16'(j);
            tv[24 + j].rd_en       = 1'b1;
            tv[24 + j].exp_rd_vld  = 1'b1;
            tv[24 + j].exp_rd_data = 16'h3000 + 16'(j);
        end

        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_wr_en = 1'b0; a_rd_en = 1'b0; a_wr_data = '0;
        b_wr_en = 1'b0; b_rd_en = 1'b0; b_wr_data = '0;
        c_wr_en = 1'b0; c_rd_en = 1'b0; c_wr_data = '0;

        // reset state
        @(negedge clk);
        chk1("rst_a_wr_vld", a_wr_vld, 1'b0);
        chk1("rst_a_rd_vld", a_rd_vld, 1'b0);
        chkw("rst_a_rd_data", 128'(a_rd_data), '0);
        chk1("rst_a_wr_ovf", a_wr_ovf, 1'b0);
        chk1("rst_b_wr_vld", b_wr_vld, 1'b0);
        chk1("rst_b_rd_vld", b_rd_vld, 1'b0);
        chkw("rst_b_rd_data", b_rd_data, '0);
        chk1("rst_c_wr_vld", c_wr_vld, 1'b0);
        chk1("rst_c_rd_vld", c_rd_vld, 1'b0);
        chk1("rst_c_wr_ovf", c_wr_ovf, 1'b0);
`ifdef SYNC_PFIFO_LEVEL_EN
        chkw("rst_a_level", 128'(a_level), '0);
`endif
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        #1;
        chk1("post_rst_a_wr_vld", a_wr_vld, 1'b1);
        chk1("post_rst_b_wr_vld", b_wr_vld, 1'b1);
        chk1("post_rst_c_wr_vld", c_wr_vld, 1'b1);

        // T1
        for (int i = 0; i < NV; i++) begin
            a_wr_en   = tv[i].wr_en;
            a_wr_data = tv[i].wr_data;
            a_rd_en   = tv[i].rd_en;
            #1;
            chk1($sformatf("t1[%0d].wr_vld", i), a_wr_vld, tv[i].exp_wr_vld);
            chk1($sformatf("t1[%0d].rd_vld", i), a_rd_vld, tv[i].exp_rd_vld);
            if (tv[i].exp_rd_vld) begin
                chkw($sformatf("t1[%0d].rd_data", i), 128'(a_rd_data), 128'(tv[i].exp_rd_data));
            end
            step();
        end
        a_wr_en = 1'b0; a_rd_en = 1'b0;

        // T2: 16->128 packing, partial pack invisible
        for (int i = 0; i < 8; i++) begin
            b_wr_en   = 1'b1;
            b_wr_data = 16'hA000 + 16'(i);
            #1;
            chk1($sformatf("t2_pack[%0d].rd_vld", i), b_rd_vld, 1'b0);
            step();
        end
        b_wr_en = 1'b0;
        #1 chk1("t2_lat1.rd_vld", b_rd_vld, 1'b0);
        step();
        #1 chk1("t2_lat2.rd_vld", b_rd_vld, 1'b0);
        step();
        #1 chk1("t2_out.rd_vld", b_rd_vld, 1'b1);
        chkw("t2_out.rd_data", b_rd_data, 128'hA007A006A005A004A003A002A001A000);
        b_rd_en = 1'b1;
        step();
        b_rd_en = 1'b0;
        #1 chk1("t2_empty.rd_vld", b_rd_vld, 1'b0);

        // T3: 128->128 AW=4 fill to 17, overflow sticky, drain in order
        for (int i = 0; i < 17; i++) begin
            c_wr_en   = 1'b1;
            c_wr_data = c_val(i);
            #1 chk1($sformatf("t3_fill[%0d].wr_vld", i), c_wr_vld, 1'b1);
            step();
        end
        #1 chk1("t3_full.wr_vld", c_wr_vld, 1'b0);
        c_wr_data = c_val(17);
        chk1("t3_pre_ovf", c_wr_ovf, 1'b0);
        step();
        c_wr_en = 1'b0;
        #1 chk1("t3_ovf_set", c_wr_ovf, 1'b1);
        step();
        step();
        #1 chk1("t3_ovf_sticky", c_wr_ovf, 1'b1);
        c_rd_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            #1;
            chk1($sformatf("t3_rd[%0d].rd_vld", i), c_rd_vld, 1'b1);
            chkw($sformatf("t3_rd[%0d].rd_data", i), c_rd_data, c_val(i));
            step();
        end
        #1;
        chk1("t3_drained.rd_vld", c_rd_vld, 1'b0);
        chk1("t3_drained.wr_vld", c_wr_vld, 1'b1);
        chk1("t3_drained.ovf", c_wr_ovf, 1'b1);

        // T4: streaming, rd_en held high throughout
        nread = 0; gaps = 0; stalls = 0;
        c_wr_en = 1'b1;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            c_wr_data = {96'h0, 32'(cyc + 1000)};
            #1;
            if (!c_wr_vld) stalls++;
            if (c_rd_vld) begin
                chkw($sformatf("t4_rd[%0d]", nread), c_rd_data, {96'h0, 32'(nread + 1000)});
                nread++;
            end else if (nread > 0) begin
                gaps++;
            end
            step();
        end
        c_wr_en = 1'b0;
        for (int cyc = 0; cyc < 20 && nread < 1000; cyc++) begin
            #1;
            if (c_rd_vld) begin
                chkw($sformatf("t4_rd[%0d]", nread), c_rd_data, {96'h0, 32'(nread + 1000)});
                nread++;
            end
            step();
        end
        chkw("t4_reads", 128'(nread), 128'(1000));
        chkw("t4_gaps", 128'(gaps), '0);
        chkw("t4_wr_stalls", 128'(stalls), '0);
        c_rd_en = 1'b0;
        #1 chk1("t4_empty.rd_vld", c_rd_vld, 1'b0);

        // T5: reset with 3 entries plus a half pack pending
        for (int i = 0; i < 28; i++) begin
            b_wr_en   = 1'b1;
            b_wr_data = 16'hB000 + 16'(i);
            step();
        end
        b_wr_en = 1'b0;
        #1 chk1("t5_pre.rd_vld", b_rd_vld, 1'b1);
        b_rst = 1'b1;
        #1 chk1("t5_in_rst.wr_vld", b_wr_vld, 1'b0);
        step();
        b_rst = 1'b0;
        #1;
        chk1("t5_post.rd_vld", b_rd_vld, 1'b0);
        chk1("t5_post.wr_vld", b_wr_vld, 1'b1);
        chk1("t5_post.wr_ovf", b_wr_ovf, 1'b0);
        chkw("t5_post.rd_data", b_rd_data, '0);
`ifdef SYNC_PFIFO_LEVEL_EN
        chkw("t5_post.level", 128'(b_level), '0);
`endif
        for (int i = 0; i < 8; i++) begin
            b_wr_en   = 1'b1;
            b_wr_data = 16'hC000 + 16'(i);
            step();
        end
        b_wr_en = 1'b0;
        for (int cyc = 0; cyc < 6 && !b_rd_vld; cyc++) begin
            step();
        end
        #1;
        chk1("t5_new.rd_vld", b_rd_vld, 1'b1);
        chkw("t5_new.rd_data", b_rd_data, 128'hC007C006C005C004C003C002C001C000);
        b_rd_en = 1'b1;
        step();
        b_rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk1($sformatf("t5_no_old[%0d].rd_vld", i), b_rd_vld, 1'b0);
            step();
        end
        b_rd_en = 1'b0;

`ifdef SYNC_PFIFO_LEVEL_EN
        // T6: level with simultaneous commit and free
        #1 chkw("t6_start.level", 128'(c_level), '0);
        for (int i = 0; i < 5; i++) begin
            c_wr_en   = 1'b1;
            c_wr_data = c_val(100 + i);
            step();
        end
        c_wr_en = 1'b0;
        step();
        step();
        step();
        #1;
        chkw("t6_five.level", 128'(c_level), 128'(5));
        chk1("t6_five.rd_vld", c_rd_vld, 1'b1);
        c_wr_en   = 1'b1;
        c_wr_data = c_val(105);
        c_rd_en   = 1'b1;
        step();
        c_rd_en = 1'b0;
        #1 chkw("t6_both.level", 128'(c_level), 128'(5));
        c_wr_data = c_val(106);
        step();
        c_wr_en = 1'b0;
        #1 chkw("t6_commit.level", 128'(c_level), 128'(6));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
